// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column, samples the synchronized
// rows, debounces whole-scan results and emits the accepted key as a hex nibble.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 32'd100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_hex,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] STABLE_N = 4'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0]       row_p0, row_p1;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             scan_hit;
  logic [3:0]       scan_code;
  logic [4:0]       prev_cand;
  logic [3:0]       stab_cnt;
  logic             scan_done;
  state_t           state, state_next;

  logic             sample;
  logic             col_hit;
  logic [3:0]       col_code;
  logic             cand_hit;
  logic [3:0]       cand_code;
  logic [4:0]       cand;
  logic             stable;
  logic             load_key;

  function automatic logic [1:0] first_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!r[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous rows
  always_ff @(posedge CLK100MHZ) begin
    row_p0 <= ROW;
    row_p1 <= row_p0;
  end

  assign COL    = ~(4'b0001 << col_idx);
  assign sample = (div_cnt == DIV_LAST);

  // Column 0 starts a fresh scan; later columns only fill in if nothing was found yet
  always_comb begin
    col_hit  = ~&row_p1;
    col_code = key_code(first_low(row_p1), col_idx);
    if (col_idx != 2'd0 && scan_hit) begin
      cand_hit  = 1'b1;
      cand_code = scan_code;
    end else begin
      cand_hit  = col_hit;
      cand_code = col_code;
    end
    cand = cand_hit ? {1'b1, cand_code} : 5'b0_0000;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      scan_hit  <= 1'b0;
      scan_code <= 4'h0;
      prev_cand <= 5'b0_0000;
      stab_cnt  <= 4'd0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (sample) begin
        div_cnt   <= '0;
        col_idx   <= col_idx + 2'd1;
        scan_hit  <= cand_hit;
        scan_code <= cand_code;
        if (col_idx == 2'd3) begin
          scan_done <= 1'b1;
          if (cand == prev_cand) begin
            if (stab_cnt < STABLE_N) stab_cnt <= stab_cnt + 4'd1;
          end else begin
            stab_cnt  <= 4'd1;
            prev_cand <= cand;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign stable = scan_done && (stab_cnt == STABLE_N);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (stable && prev_cand[4])  state_next = HELD;
      HELD:    if (stable && !prev_cand[4]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rollover: a different stable key while held is accepted as a new press
  always_comb begin
    load_key = 1'b0;
    if (stable && prev_cand[4])
      load_key = (state == IDLE) || (prev_cand[3:0] != key_hex);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      key_hex   <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= load_key;
      key_down  <= (state_next == HELD);
      if (load_key) key_hex <= prev_cand[3:0];
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scans);
// the keypad is modelled combinationally from COL.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_hex;
  logic        key_valid;
  logic        key_down;
  logic [15:0] press = 16'h0000;

  int          cyc = 0;
  int          pulse_cnt = 0;
  int          pulse_cyc = 0;
  int          dbl = 0;
  logic [3:0]  pulse_hex = 4'h0;
  logic        prev_v = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .ROW(row),
    .COL(col),
    .key_hex(key_hex),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  // press[r*4+c] closes the switch between row r and column c
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      pulse_cnt = 0;
    end else if (key_valid) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
      pulse_hex = key_hex;
    end
    if (key_valid && prev_v) dbl = dbl + 1;
    prev_v = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick(1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    check("rst_col", col, 4'b1110);
    check("rst_hex", key_hex, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] exp_code(input int r, input int c);
    logic [3:0] v;
    case (r*4 + c)
      0: v = 4'h1;  1: v = 4'h2;  2: v = 4'h3;  3: v = 4'hA;
      4: v = 4'h4;  5: v = 4'h5;  6: v = 4'h6;  7: v = 4'hB;
      8: v = 4'h7;  9: v = 4'h8; 10: v = 4'h9; 11: v = 4'hC;
      12: v = 4'h0; 13: v = 4'hF; 14: v = 4'hE; default: v = 4'hD;
    endcase
    return v;
  endfunction

  localparam int K5 = 1*4 + 1;
  localparam int KA = 0*4 + 3;
  localparam int KD = 3*4 + 3;
  localparam int K9 = 2*4 + 2;
  localparam int K2 = 0*4 + 1;
  localparam int KF = 3*4 + 1;
  localparam int K7 = 2*4 + 0;

  initial begin
    logic [3:0] e;
    tick(1);

    // 1. reset then idle
    press = '0;
    do_reset(3);
    for (int k = 1; k <= 32; k++) begin
      run_to(k);
      e = 4'hF ^ (4'h1 << ((k / 4) % 4));
      check("idle_col", col, e);
    end
    run_to(64);
    check("idle_pulses", pulse_cnt, 0);
    check("idle_hex", key_hex, 4'h0);
    check("idle_down", key_down, 1'b0);

    // 2. clean press of '5'
    press = '0;
    press[K5] = 1'b1;
    do_reset(2);
    run_to(32);
    check("p5_early", pulse_cnt, 0);
    check("p5_down_early", key_down, 1'b0);
    run_to(33);
    check("p5_valid", key_valid, 1'b1);
    check("p5_hex", key_hex, 4'h5);
    check("p5_down", key_down, 1'b1);
    run_to(34);
    check("p5_valid_drop", key_valid, 1'b0);
    run_to(80);
    check("p5_pulses", pulse_cnt, 1);
    check("p5_pulse_cyc", pulse_cyc, 33);
    check("p5_still_down", key_down, 1'b1);

    // 3. bounce of 'A', toggled every scan for 6 scans, then held
    press = '0;
    do_reset(2);
    for (int s = 0; s < 6; s++) begin
      press = '0;
      press[KA] = (s % 2 == 0);
      run_to(16 * (s + 1));
    end
    check("bnc_quiet", pulse_cnt, 0);
    press = '0;
    press[KA] = 1'b1;
    run_to(128);
    check("bnc_before", pulse_cnt, 0);
    run_to(129);
    check("bnc_valid", key_valid, 1'b1);
    check("bnc_hex", key_hex, 4'hA);
    run_to(150);
    check("bnc_pulses", pulse_cnt, 1);

    // 4. hold '5', roll over to 'D', then release
    press = '0;
    press[K5] = 1'b1;
    do_reset(2);
    run_to(48);
    check("ro_first", pulse_hex, 4'h5);
    press = '0;
    press[KD] = 1'b1;
    run_to(64);
    check("ro_down_switch", key_down, 1'b1);
    check("ro_hex_hold", key_hex, 4'h5);
    run_to(80);
    check("ro_down_pre", key_down, 1'b1);
    run_to(81);
    check("ro_valid", key_valid, 1'b1);
    check("ro_hex", key_hex, 4'hD);
    check("ro_down", key_down, 1'b1);
    run_to(96);
    press = '0;
    run_to(128);
    check("rel_down_pre", key_down, 1'b1);
    run_to(129);
    check("rel_down", key_down, 1'b0);
    check("rel_hex", key_hex, 4'hD);
    run_to(160);
    check("rel_pulses", pulse_cnt, 2);

    // 5. multi-key priority: column order, then row order within a column
    press = '0;
    press[K9] = 1'b1;
    press[K2] = 1'b1;
    do_reset(2);
    run_to(64);
    check("pri_col_hex", pulse_hex, 4'h2);
    check("pri_col_pulses", pulse_cnt, 1);
    press = '0;
    press[KF] = 1'b1;
    press[K5] = 1'b1;
    do_reset(2);
    run_to(64);
    check("pri_row_hex", pulse_hex, 4'h5);
    check("pri_row_pulses", pulse_cnt, 1);

    // 6. reset after one stable scan of '7'
    press = '0;
    press[K7] = 1'b1;
    do_reset(2);
    run_to(20);
    do_reset(1);
    run_to(32);
    check("mid_early", pulse_cnt, 0);
    run_to(33);
    check("mid_valid", key_valid, 1'b1);
    check("mid_hex", key_hex, 4'h7);

    // full key map
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        press = '0;
        press[r*4+c] = 1'b1;
        do_reset(2);
        run_to(34);
        check($sformatf("map_r%0dc%0d", r, c), pulse_hex, exp_code(r, c));
        check($sformatf("map_cyc_r%0dc%0d", r, c), pulse_cyc, 33);
      end

    check("no_double_valid", dbl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
